// File: rtl/kitchen_responder.sv
// Purpose: responder side of the chef command link; walks the chef along the machine row and runs timed actions.
// Latency: STEP_CYCLES per position travelled (+1 cycle to report arrival); ACT_CYCLES per action; all outputs registered.
// Backpressure: move_ready stays low while idle or moving; commands and action edges that arrive while busy are ignored or flagged as errors.
module kitchen_responder #(
   parameter int NUM_MACHINES = 20,
   parameter int STEP_CYCLES  = 4,
   parameter int ACT_CYCLES   = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] control_data,
   input  logic [7:0] i_num,
   output logic [7:0] feedback_sig,
   output logic [7:0] position
);

   localparam int SW = $clog2(STEP_CYCLES + 1);
   localparam int AW = $clog2(ACT_CYCLES + 1);
   localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
   localparam logic [AW-1:0] ACT_LAST  = AW'(ACT_CYCLES - 1);
   localparam logic [7:0]    NUM_M     = 8'(NUM_MACHINES);

   localparam logic [2:0] OP_NONE     = 3'b000;
   localparam logic [2:0] OP_GET      = 3'b001;
   localparam logic [2:0] OP_PUT      = 3'b010;
   localparam logic [2:0] OP_INTERACT = 3'b011;
   localparam logic [2:0] OP_THROW    = 3'b100;

   typedef enum logic [1:0] {ST_IDLE, ST_MOVING, ST_AT_TARGET, ST_EXEC} state_t;

   state_t        state, state_d;
   logic [7:0]    pos_d, target, target_d;
   logic [SW-1:0] step_cnt, step_d;
   logic [AW-1:0] act_cnt, act_d;
   logic [3:0]    prev_act, act_rise;
   logic [2:0]    op, op_d, last_op, last_op_d;
   logic          holding, holding_d;
   logic          error, error_d;
   logic          done_d;
   logic          busy_d, ready_d;

   // Next-state, travel, action execution and effect application.
   always_comb begin
      state_d   = state;
      pos_d     = position;
      target_d  = target;
      step_d    = step_cnt;
      act_d     = act_cnt;
      op_d      = op;
      last_op_d = last_op;
      holding_d = holding;
      error_d   = error;
      done_d    = 1'b0;
      act_rise  = control_data[3:0] & ~prev_act;

      case (state)
         ST_IDLE, ST_AT_TARGET: begin
            // An action edge outranks a simultaneous move request.
            if (state == ST_AT_TARGET && act_rise != 4'd0) begin
               if ((act_rise & (act_rise - 4'd1)) == 4'd0) begin
                  state_d = ST_EXEC;
                  act_d   = '0;
                  error_d = 1'b0;
                  case (act_rise)
                     4'b1000: op_d = OP_GET;
                     4'b0100: op_d = OP_PUT;
                     4'b0010: op_d = OP_INTERACT;
                     default: op_d = OP_THROW;
                  endcase
               end else begin
                  error_d = 1'b1;
               end
            end else if (control_data[4]) begin
               if (i_num >= NUM_M) begin
                  error_d = 1'b1;
               end else if (i_num != position) begin
                  target_d = i_num;
                  error_d  = 1'b0;
                  step_d   = '0;
                  state_d  = ST_MOVING;
               end else begin
                  error_d = 1'b0;
                  state_d = ST_AT_TARGET;
               end
            end
         end
         ST_MOVING: begin
            // Arrival is reported one cycle after the final step lands.
            if (position == target) begin
               state_d = ST_AT_TARGET;
            end else if (step_cnt == STEP_LAST) begin
               step_d = '0;
               pos_d  = (position < target) ? position + 8'd1 : position - 8'd1;
            end else begin
               step_d = step_cnt + SW'(1);
            end
         end
         default: begin
            if (act_rise != 4'd0) error_d = 1'b1;
            if (act_cnt == ACT_LAST) begin
               done_d    = 1'b1;
               last_op_d = op;
               state_d   = ST_AT_TARGET;
               case (op)
                  OP_GET: begin
                     if (holding) error_d = 1'b1;
                     else         holding_d = 1'b1;
                  end
                  OP_PUT: begin
                     if (holding) holding_d = 1'b0;
                     else         error_d = 1'b1;
                  end
                  OP_THROW: holding_d = 1'b0;
                  default:  ;
               endcase
            end else begin
               act_d = act_cnt + AW'(1);
            end
         end
      endcase

      busy_d  = (state_d == ST_MOVING) || (state_d == ST_EXEC);
      ready_d = (state_d == ST_AT_TARGET) || (state_d == ST_EXEC);
   end

   // State, datapath and the registered feedback word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         position     <= 8'd0;
         target       <= 8'd0;
         step_cnt     <= '0;
         act_cnt      <= '0;
         prev_act     <= 4'd0;
         op           <= OP_NONE;
         last_op      <= OP_NONE;
         holding      <= 1'b0;
         error        <= 1'b0;
         feedback_sig <= 8'h00;
      end else begin
         state        <= state_d;
         position     <= pos_d;
         target       <= target_d;
         step_cnt     <= step_d;
         act_cnt      <= act_d;
         prev_act     <= control_data[3:0];
         op           <= op_d;
         last_op      <= last_op_d;
         holding      <= holding_d;
         error        <= error_d;
         feedback_sig <= {last_op_d, error_d, busy_d, ready_d, done_d, holding_d};
      end
   end

endmodule

// File: tb/tb_kitchen_responder.sv
// Purpose: randomized and directed checking of kitchen_responder against a timestamp-based reference model.
// Latency: outputs compared 1 time unit after every rising clock edge.
// Backpressure: none; stimulus is free-running.
module tb_kitchen_responder;

   localparam int NM   = 20;
   localparam int STEP = 4;
   localparam int ACT  = 3;

   localparam int M_IDLE   = 0;
   localparam int M_MOVING = 1;
   localparam int M_AT     = 2;
   localparam int M_EXEC   = 3;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic [4:0] cd    = 5'd0;
   logic [7:0] inum  = 8'd0;
   logic [7:0] feedback_sig;
   logic [7:0] position;

   kitchen_responder #(
      .NUM_MACHINES(NM),
      .STEP_CYCLES (STEP),
      .ACT_CYCLES  (ACT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .control_data(cd),
      .i_num       (inum),
      .feedback_sig(feedback_sig),
      .position    (position)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 8'h%02h expected 8'h%02h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: a move or action is remembered by its start time and
   // its outcome is derived from elapsed cycles.
   int         m_mode, m_pos, m_tgt, m_start, m_t0, m_cyc;
   logic [3:0] m_prev;
   logic [2:0] m_op, m_last;
   logic       m_hold, m_err, m_done;

   task model_reset();
      m_mode  = M_IDLE;
      m_pos   = 0;
      m_tgt   = 0;
      m_start = 0;
      m_t0    = 0;
      m_cyc   = 0;
      m_prev  = 4'd0;
      m_op    = 3'd0;
      m_last  = 3'd0;
      m_hold  = 1'b0;
      m_err   = 1'b0;
      m_done  = 1'b0;
   endtask

   task model_step();
      logic [3:0] rise;
      int         k, d;
      m_cyc++;
      rise   = cd[3:0] & ~m_prev;
      m_prev = cd[3:0];
      m_done = 1'b0;
      if (m_mode == M_IDLE || m_mode == M_AT) begin
         if (m_mode == M_AT && rise != 4'd0) begin
            if ($countones(rise) == 1) begin
               m_mode = M_EXEC;
               m_t0   = m_cyc;
               m_err  = 1'b0;
               m_op   = rise[3] ? 3'd1 : rise[2] ? 3'd2 : rise[1] ? 3'd3 : 3'd4;
            end else begin
               m_err = 1'b1;
            end
         end else if (cd[4]) begin
            if (int'(inum) >= NM) begin
               m_err = 1'b1;
            end else if (int'(inum) != m_pos) begin
               m_mode  = M_MOVING;
               m_start = m_pos;
               m_tgt   = int'(inum);
               m_t0    = m_cyc;
               m_err   = 1'b0;
            end else begin
               m_mode = M_AT;
               m_err  = 1'b0;
            end
         end
      end else if (m_mode == M_MOVING) begin
         k = m_cyc - m_t0;
         d = (m_tgt > m_start) ? m_tgt - m_start : m_start - m_tgt;
         if (k > d * STEP)          m_mode = M_AT;
         else if (m_tgt > m_start)  m_pos  = m_start + k / STEP;
         else                       m_pos  = m_start - k / STEP;
      end else begin
         if (rise != 4'd0) m_err = 1'b1;
         if (m_cyc - m_t0 == ACT) begin
            m_done = 1'b1;
            m_last = m_op;
            m_mode = M_AT;
            case (m_op)
               3'd1: if (m_hold) m_err = 1'b1; else m_hold = 1'b1;
               3'd2: if (m_hold) m_hold = 1'b0; else m_err = 1'b1;
               3'd4: m_hold = 1'b0;
               default: ;
            endcase
         end
      end
   endtask

   function automatic logic [7:0] model_fb();
      logic busy, ready;
      busy  = (m_mode == M_MOVING) || (m_mode == M_EXEC);
      ready = (m_mode == M_AT) || (m_mode == M_EXEC);
      return {m_last, m_err, busy, ready, m_done, m_hold};
   endfunction

   task cycle();
      @(posedge clk);
      if (rst_n) model_step();
      #1;
      check("fb", feedback_sig, model_fb());
      check("pos", position, 8'(m_pos));
   endtask

   // Asynchronous reset is checked before any clock edge can act on it.
   task apply_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      check("arst_fb", feedback_sig, 8'h00);
      check("arst_pos", position, 8'h00);
      cycle();
      cycle();
      rst_n = 1'b1;
   endtask

   int n_done, done_k;

   initial begin
      #2;
      apply_reset();

      // Travel 0 -> 3.
      cd = 5'b10000; inum = 8'd3;
      for (int k = 1; k <= 14; k++) begin
         cycle();
         if (k == 1)  check("move_busy", {6'd0, feedback_sig[3:2]}, 8'd2);
         if (k == 5)  check("move_pos1", position, 8'd1);
         if (k == 9)  check("move_pos2", position, 8'd2);
         if (k == 13) check("move_pos3_notready", {position[3:0], 3'd0, feedback_sig[2]}, 8'h30);
         if (k == 14) check("arrive_fb", feedback_sig, 8'h04);
      end
      cd = 5'b00000; cycle();

      // get held for 20 cycles fires once.
      n_done = 0; done_k = 0;
      cd = 5'b01000;
      for (int k = 1; k <= 20; k++) begin
         cycle();
         if (feedback_sig[1]) begin n_done++; done_k = k; end
      end
      check("get_done_count", 8'(n_done), 8'd1);
      check("get_done_cycle", 8'(done_k), 8'(ACT + 1));
      check("get_fb", feedback_sig, 8'h25);

      // put, then put again with empty hands.
      cd = 5'b00000; cycle();
      cd = 5'b00100; for (int k = 0; k < 6; k++) cycle();
      check("put_fb", feedback_sig, 8'h44);
      cd = 5'b00000; cycle();
      n_done = 0;
      cd = 5'b00100;
      for (int k = 0; k < 6; k++) begin
         cycle();
         if (feedback_sig[1]) n_done++;
      end
      check("put2_done_count", 8'(n_done), 8'd1);
      check("put2_fb", feedback_sig, 8'h54);

      // Out-of-range target, then travel back to 0.
      cd = 5'b10000; inum = 8'd25;
      for (int k = 0; k < 3; k++) cycle();
      check("bad_tgt_fb", feedback_sig, 8'h54);
      check("bad_tgt_pos", position, 8'd3);
      inum = 8'd0;
      for (int k = 1; k <= 14; k++) begin
         cycle();
         if (k == 12) check("back_pos1", position, 8'd1);
         if (k == 13) check("back_pos0", position, 8'd0);
      end
      check("back_fb", feedback_sig, 8'h44);

      // Two simultaneous action edges.
      cd = 5'b00000; cycle();
      n_done = 0;
      cd = 5'b01001;
      for (int k = 0; k < 4; k++) begin
         cycle();
         if (feedback_sig[1]) n_done++;
      end
      check("multi_done_count", 8'(n_done), 8'd0);
      check("multi_fb", feedback_sig, 8'h54);

      // interact edge while a get is executing.
      cd = 5'b00000; cycle();
      cd = 5'b01000; cycle();
      cd = 5'b01010;
      for (int k = 0; k < 5; k++) cycle();
      check("drop_fb", feedback_sig, 8'h35);

      // Reset in the middle of a move at position 2.
      cd = 5'b00000; cycle();
      cd = 5'b10000; inum = 8'd5;
      for (int k = 0; k < 10; k++) cycle();
      check("pre_rst_pos", position, 8'd2);
      cd = 5'b00000;
      apply_reset();
      for (int k = 0; k < 4; k++) cycle();
      check("idle_wait_fb", feedback_sig, 8'h00);

      // Randomized phase.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 2) == 0) begin
            int r;
            logic [3:0] acts;
            r = int'($urandom_range(0, 9));
            if (r < 5)      acts = 4'd0;
            else if (r < 9) acts = 4'd1 << $urandom_range(0, 3);
            else            acts = 4'($urandom_range(0, 15));
            cd   = {($urandom_range(0, 3) == 0), acts};
            inum = 8'($urandom_range(0, 23));
         end
         if ($urandom_range(0, 399) == 0) apply_reset();
         else                             cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/kitchen_responder.md
Name: kitchen_responder

Overview:
- Responder end of the chef command interface.
- Consumes the 5-bit control_data word (move/get/put/interact/throw) and the target machine number.
- Models chef travel along the machine row and timed action execution.
- Drives the 8-bit feedback_sig back to the command side; feedback_sig[2] (move_ready) gates the command side's action enables.

Parameters:
NUM_MACHINES, 20, number of valid machine positions (0..NUM_MACHINES-1)
STEP_CYCLES, 4, clock cycles to travel one position (>=1)
ACT_CYCLES, 3, clock cycles to execute one action (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
control_data  input  5  {move_en, get_en, put_en, interact_en, throw_en}, levels
i_num  input  8  target machine number
feedback_sig  output  8  [0] holding, [1] action_done, [2] move_ready, [3] busy, [4] error, [7:5] last_op
position  output  8  current chef position, for display

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, position=0, target=0, step/act counters=0.
  - prev_act=4'b0 (registered copy of control_data[3:0]).
  - feedback_sig=8'h00.
  - Deassertion takes effect at the next clk edge.
- Reset mid-move or mid-action: all of the above is abandoned immediately; no partial effect is applied.
- States:
  - IDLE: move_ready=0, busy=0.
  - MOVING: busy=1, move_ready=0.
  - AT_TARGET: move_ready=1, busy=0.
  - EXEC: move_ready=1, busy=1.
- Action edge detection:
  - act_rise = control_data[3:0] & ~prev_act; prev_act updates every cycle in every state.
  - Actions trigger only on act_rise; a held level never re-triggers.
- IDLE / AT_TARGET with move_en=1:
  - i_num >= NUM_MACHINES: set error; no state change.
  - i_num != position: latch target=i_num, clear error, go MOVING, step counter=0.
  - i_num == position: go or stay in AT_TARGET, clear error.
- MOVING:
  - Step counter counts 0..STEP_CYCLES-1.
  - On terminal count, position moves one toward target (+1 or -1) and the counter wraps to 0.
  - When the updated position == target, go AT_TARGET; move_ready=1 in the following cycle.
  - i_num changes and all control_data are ignored while MOVING.
  - Travel over d positions takes d*STEP_CYCLES cycles.
- AT_TARGET action acceptance:
  - If act_rise has exactly one bit set: go EXEC, latch the op, act counter=0, clear error.
  - If act_rise has more than one bit set: set error, stay in AT_TARGET.
  - move_en=1 with a new i_num is handled as above; when the same cycle also has an act_rise, the action wins.
- EXEC:
  - Runs ACT_CYCLES cycles; inputs are ignored.
  - act_rise during EXEC is dropped and sets error.
  - On the final cycle, apply the effect, pulse action_done=1 for exactly one cycle, write last_op, return to AT_TARGET.
- Effects:
  - get: holding=0 -> holding=1; holding=1 -> error, no change.
  - put: holding=1 -> holding=0; holding=0 -> error.
  - throw: holding=0 unconditionally.
  - interact: no holding change.
- last_op encoding: 3'b001 get, 010 put, 011 interact, 100 throw, 000 none (reset).
- Error is sticky until the next accepted move or action.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset, then control_data=5'b10000, i_num=3 -> busy=1, move_ready=0; position reaches 1, 2, 3 at +4, +8, +12 cycles; move_ready=1 the cycle after position=3; feedback_sig=8'h04.
- At pos 3, get_en rises and is held high for 20 cycles -> exactly one action_done pulse ACT_CYCLES cycles after the edge; then holding=1, last_op=001; no second pulse.
- Holding=1, put rises -> holding=0, last_op=010. Put rises again -> error=1, holding stays 0, action_done still pulses.
- At pos 3, move_en with i_num=25 -> error=1, position stays 3, state AT_TARGET; then move_en with i_num=0 -> error clears, position counts down to 0 in 12 cycles.
- get_en and throw_en rise in the same cycle -> error=1, no EXEC, action_done stays 0; interact rising during EXEC -> dropped, error=1.
- Assert rst_n=0 mid-move at position 2 -> feedback_sig=8'h00 and position=0 immediately, without waiting for a clock edge; after release, the block waits in IDLE with move_ready=0 until the next move_en.
